// File: rtl/hvac_sched_ctrl.sv
// hvac_sched_ctrl: heater/cooler sequencer driven by the temperature sensor.
// Adds hysteresis, a minimum run time, a post-run compressor lockout and a
// fire-alarm / enable abort. Only one actuator can be on at any time.
//
// Ports
//   Clk        in   1       system clock, rising edge
//   Rst        in   1       asynchronous active-high reset
//   en         in   1       HVAC enable; 0 blocks new runs and aborts a run
//   SFA        in   1       fire alarm; 1 blocks new runs and aborts a run
//   ST         in   TEMP_W  temperature, unsigned
//   heater     out  1       heater drive (registered)
//   cooler     out  1       cooler drive (registered)
//   hvac_state out  2       00 IDLE, 01 HEAT, 10 COOL, 11 LOCKOUT
module hvac_sched_ctrl #(
  parameter int unsigned TEMP_W      = 7,
  parameter int unsigned HEAT_ON_TH  = 50,
  parameter int unsigned HEAT_OFF_TH = 60,
  parameter int unsigned COOL_ON_TH  = 80,
  parameter int unsigned COOL_OFF_TH = 70,
  parameter int unsigned MIN_RUN     = 8,
  parameter int unsigned LOCKOUT     = 4,
  parameter int unsigned CNT_W       = 8
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              en,
  input  logic              SFA,
  input  logic [TEMP_W-1:0] ST,
  output logic              heater,
  output logic              cooler,
  output logic [1:0]        hvac_state
);

  localparam logic [TEMP_W-1:0] HEAT_ON   = TEMP_W'(HEAT_ON_TH);
  localparam logic [TEMP_W-1:0] HEAT_OFF  = TEMP_W'(HEAT_OFF_TH);
  localparam logic [TEMP_W-1:0] COOL_ON   = TEMP_W'(COOL_ON_TH);
  localparam logic [TEMP_W-1:0] COOL_OFF  = TEMP_W'(COOL_OFF_TH);
  localparam logic [CNT_W-1:0]  RUN_INIT  = CNT_W'(MIN_RUN - 1);
  localparam logic [CNT_W-1:0]  LOCK_INIT = CNT_W'(LOCKOUT - 1);

  // Reject parameter sets that break the hysteresis ordering or overflow the counters.
  if (!(HEAT_ON_TH < HEAT_OFF_TH && HEAT_OFF_TH <= COOL_OFF_TH && COOL_OFF_TH < COOL_ON_TH)
      || MIN_RUN < 1 || MIN_RUN >= (1 << CNT_W)
      || LOCKOUT < 1 || LOCKOUT >= (1 << CNT_W)) begin : g_param_check
    $error("hvac_sched_ctrl: illegal parameter set");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_HEAT = 2'b01,
    S_COOL = 2'b10,
    S_LOCK = 2'b11
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] run_cnt, run_nxt;
  logic [CNT_W-1:0] lock_cnt, lock_nxt;
  logic             abort;

  // State, counters and actuator registers.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state    <= S_IDLE;
      run_cnt  <= '0;
      lock_cnt <= '0;
      heater   <= 1'b0;
      cooler   <= 1'b0;
    end else begin
      state    <= state_nxt;
      run_cnt  <= run_nxt;
      lock_cnt <= lock_nxt;
      // Registered from the next state so the pins never see decode glitches.
      heater   <= (state_nxt == S_HEAT);
      cooler   <= (state_nxt == S_COOL);
    end
  end

  assign hvac_state = state;

  // Next-state and counter update.
  always_comb begin
    state_nxt = state;
    run_nxt   = (run_cnt == '0) ? '0 : run_cnt - CNT_W'(1);
    lock_nxt  = (lock_cnt == '0) ? '0 : lock_cnt - CNT_W'(1);
    abort     = SFA || !en;

    case (state)
      S_IDLE: begin
        if (!abort) begin
          if (ST < HEAT_ON) begin
            state_nxt = S_HEAT;
            run_nxt   = RUN_INIT;
          end else if (ST > COOL_ON) begin
            state_nxt = S_COOL;
            run_nxt   = RUN_INIT;
          end
        end
      end
      S_HEAT: begin
        // Abort wins over the minimum run time.
        if (abort || (run_cnt == '0 && ST >= HEAT_OFF)) begin
          state_nxt = S_LOCK;
          lock_nxt  = LOCK_INIT;
        end
      end
      S_COOL: begin
        if (abort || (run_cnt == '0 && ST <= COOL_OFF)) begin
          state_nxt = S_LOCK;
          lock_nxt  = LOCK_INIT;
        end
      end
      S_LOCK: begin
        // Fixed-length lockout, insensitive to SFA, en and ST.
        if (lock_cnt == '0) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_hvac_sched_ctrl.sv
// Testbench for hvac_sched_ctrl: directed scenarios with constant expectations,
// then randomized traffic checked against an elapsed-time behavioural model.
module tb_hvac_sched_ctrl;

  localparam int unsigned MIN_RUN = 8;
  localparam int unsigned LOCKOUT = 4;

  logic       Clk = 1'b0;
  logic       Rst;
  logic       en;
  logic       SFA;
  logic [6:0] ST;
  logic       heater;
  logic       cooler;
  logic [1:0] hvac_state;

  int n_checks = 0;
  int n_errors = 0;

  // Model: mode code as seen on hvac_state, plus elapsed cycles in run / lockout.
  int m_mode;
  int m_on;
  int m_lk;

  typedef struct {
    int         st;
    bit         sfa;
    bit         en;
    logic [1:0] exp;
  } step_t;

  hvac_sched_ctrl dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .en         (en),
    .SFA        (SFA),
    .ST         (ST),
    .heater     (heater),
    .cooler     (cooler),
    .hvac_state (hvac_state)
  );

  always #5 Clk = ~Clk;

  task automatic model_reset();
    m_mode = 0;
    m_on   = 0;
    m_lk   = 0;
  endtask

  // One clock period of the controller, computed from the behavioural rules.
  task automatic model_step();
    int t;
    t = int'(ST);
    case (m_mode)
      0: if (!SFA && en) begin
           if (t < 50)      begin m_mode = 1; m_on = 1; end
           else if (t > 80) begin m_mode = 2; m_on = 1; end
         end
      1: if (SFA || !en || (m_on >= int'(MIN_RUN) && t >= 60)) begin m_mode = 3; m_lk = 1; end
         else m_on++;
      2: if (SFA || !en || (m_on >= int'(MIN_RUN) && t <= 70)) begin m_mode = 3; m_lk = 1; end
         else m_on++;
      default: if (m_lk >= int'(LOCKOUT)) m_mode = 0;
               else m_lk++;
    endcase
  endtask

  // Advance one clock edge; outputs are settled 1 time unit later.
  task automatic tick();
    @(posedge Clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    step_t seq[$];
    Rst = 1'b1; en = 1'b1; SFA = 1'b0; ST = 7'd55;
    #3;
    n_checks++;
    if ({heater, cooler, hvac_state} !== 4'b0000) begin
      n_errors++;
      $display("FAIL reset_async: got h=%b c=%b s=%b want 0 0 00", heater, cooler, hvac_state);
    end
    @(posedge Clk); #1;
    n_checks++;
    if ({heater, cooler, hvac_state} !== 4'b0000) begin
      n_errors++;
      $display("FAIL reset_held: got h=%b c=%b s=%b want 0 0 00", heater, cooler, hvac_state);
    end
    @(negedge Clk);
    Rst = 1'b0;
    model_reset();
    for (int i = 0; i < 10; i++) seq.push_back('{55, 1'b0, 1'b1, 2'b00});
    foreach (seq[i]) begin
      ST = 7'(seq[i].st); SFA = seq[i].sfa; en = seq[i].en;
      tick();
      n_checks++;
      if ({heater, cooler, hvac_state} !== {seq[i].exp == 2'd1, seq[i].exp == 2'd2, seq[i].exp}) begin
        n_errors++;
        $display("FAIL dead_band step %0d: got h=%b c=%b s=%b want s=%b", i, heater, cooler, hvac_state, seq[i].exp);
      end
    end
  endtask

  task automatic test_heat_min_run();
    step_t seq[$];
    for (int i = 0; i < 3; i++)  seq.push_back('{40, 1'b0, 1'b1, 2'b01});
    for (int i = 0; i < 5; i++)  seq.push_back('{65, 1'b0, 1'b1, 2'b01});
    for (int i = 0; i < 4; i++)  seq.push_back('{65, 1'b0, 1'b1, 2'b11});
    for (int i = 0; i < 3; i++)  seq.push_back('{55, 1'b0, 1'b1, 2'b00});
    foreach (seq[i]) begin
      ST = 7'(seq[i].st); SFA = seq[i].sfa; en = seq[i].en;
      tick();
      n_checks++;
      if ({heater, cooler, hvac_state} !== {seq[i].exp == 2'd1, seq[i].exp == 2'd2, seq[i].exp}) begin
        n_errors++;
        $display("FAIL heat_min_run step %0d: got h=%b c=%b s=%b want s=%b", i, heater, cooler, hvac_state, seq[i].exp);
      end
    end
  endtask

  task automatic test_cool_hysteresis();
    step_t seq[$];
    seq.push_back('{90, 1'b0, 1'b1, 2'b10});
    for (int i = 0; i < 10; i++) seq.push_back('{75, 1'b0, 1'b1, 2'b10});
    for (int i = 0; i < 4; i++)  seq.push_back('{70, 1'b0, 1'b1, 2'b11});
    for (int i = 0; i < 2; i++)  seq.push_back('{55, 1'b0, 1'b1, 2'b00});
    foreach (seq[i]) begin
      ST = 7'(seq[i].st); SFA = seq[i].sfa; en = seq[i].en;
      tick();
      n_checks++;
      if ({heater, cooler, hvac_state} !== {seq[i].exp == 2'd1, seq[i].exp == 2'd2, seq[i].exp}) begin
        n_errors++;
        $display("FAIL cool_hyst step %0d: got h=%b c=%b s=%b want s=%b", i, heater, cooler, hvac_state, seq[i].exp);
      end
    end
  endtask

  task automatic test_abort();
    step_t seq[$];
    // Fire alarm in the 3rd heat cycle, then alarm held with heat demand.
    for (int i = 0; i < 3; i++) seq.push_back('{40, 1'b0, 1'b1, 2'b01});
    for (int i = 0; i < 4; i++) seq.push_back('{40, 1'b1, 1'b1, 2'b11});
    for (int i = 0; i < 3; i++) seq.push_back('{40, 1'b1, 1'b1, 2'b00});
    seq.push_back('{40, 1'b0, 1'b1, 2'b01});
    for (int i = 0; i < 7; i++) seq.push_back('{65, 1'b0, 1'b1, 2'b01});
    for (int i = 0; i < 4; i++) seq.push_back('{65, 1'b0, 1'b1, 2'b11});
    seq.push_back('{55, 1'b0, 1'b1, 2'b00});
    // Enable dropped mid-run.
    seq.push_back('{40, 1'b0, 1'b1, 2'b01});
    for (int i = 0; i < 4; i++) seq.push_back('{40, 1'b0, 1'b0, 2'b11});
    for (int i = 0; i < 2; i++) seq.push_back('{40, 1'b0, 1'b0, 2'b00});
    seq.push_back('{55, 1'b0, 1'b1, 2'b00});
    foreach (seq[i]) begin
      ST = 7'(seq[i].st); SFA = seq[i].sfa; en = seq[i].en;
      tick();
      n_checks++;
      if ({heater, cooler, hvac_state} !== {seq[i].exp == 2'd1, seq[i].exp == 2'd2, seq[i].exp}) begin
        n_errors++;
        $display("FAIL abort step %0d: got h=%b c=%b s=%b want s=%b", i, heater, cooler, hvac_state, seq[i].exp);
      end
    end
  endtask

  task automatic test_heat_to_cool();
    step_t seq[$];
    seq.push_back('{40, 1'b0, 1'b1, 2'b01});
    for (int i = 0; i < 7; i++) seq.push_back('{90, 1'b0, 1'b1, 2'b01});
    for (int i = 0; i < 4; i++) seq.push_back('{90, 1'b0, 1'b1, 2'b11});
    seq.push_back('{90, 1'b0, 1'b1, 2'b00});
    for (int i = 0; i < 3; i++) seq.push_back('{90, 1'b0, 1'b1, 2'b10});
    foreach (seq[i]) begin
      ST = 7'(seq[i].st); SFA = seq[i].sfa; en = seq[i].en;
      tick();
      n_checks++;
      if ({heater, cooler, hvac_state} !== {seq[i].exp == 2'd1, seq[i].exp == 2'd2, seq[i].exp}) begin
        n_errors++;
        $display("FAIL heat_to_cool step %0d: got h=%b c=%b s=%b want s=%b", i, heater, cooler, hvac_state, seq[i].exp);
      end
      n_checks++;
      if ((heater & cooler) !== 1'b0) begin
        n_errors++;
        $display("FAIL heat_to_cool_excl step %0d: got h&c=%b want 0", i, heater & cooler);
      end
    end
  endtask

  // Left in COOL by the previous test; pulse reset between edges.
  task automatic test_async_reset();
    @(negedge Clk);
    #2;
    Rst = 1'b1;
    #1;
    n_checks++;
    if ({heater, cooler, hvac_state} !== 4'b0000) begin
      n_errors++;
      $display("FAIL async_reset_out: got h=%b c=%b s=%b want 0 0 00", heater, cooler, hvac_state);
    end
    n_checks++;
    if ({dut.run_cnt, dut.lock_cnt} !== 16'h0000) begin
      n_errors++;
      $display("FAIL async_reset_cnt: got run=%0d lock=%0d want 0 0", dut.run_cnt, dut.lock_cnt);
    end
    ST = 7'd55;
    @(negedge Clk);
    Rst = 1'b0;
    model_reset();
    tick();
    n_checks++;
    if ({heater, cooler, hvac_state} !== 4'b0000) begin
      n_errors++;
      $display("FAIL async_reset_idle: got h=%b c=%b s=%b want 0 0 00", heater, cooler, hvac_state);
    end
  endtask

  task automatic test_random();
    int zone;
    for (int i = 0; i < 3000; i++) begin
      zone = int'($urandom_range(0, 9));
      if (zone < 3)      ST = 7'($urandom_range(0, 55));
      else if (zone < 6) ST = 7'($urandom_range(55, 75));
      else if (zone < 9) ST = 7'($urandom_range(70, 127));
      else               ST = 7'($urandom_range(0, 127));
      SFA = ($urandom_range(0, 99) < 3);
      en  = ($urandom_range(0, 99) >= 4);
      tick();
      n_checks++;
      if ({heater, cooler, hvac_state} !== {m_mode == 1, m_mode == 2, 2'(m_mode)}) begin
        n_errors++;
        $display("FAIL random cyc %0d: got h=%b c=%b s=%b want s=%0d", i, heater, cooler, hvac_state, m_mode);
      end
      n_checks++;
      if ((heater & cooler) !== 1'b0) begin
        n_errors++;
        $display("FAIL random_excl cyc %0d: got h&c=%b want 0", i, heater & cooler);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_heat_min_run();
    test_cool_hysteresis();
    test_abort();
    test_heat_to_cool();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
